// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for a shared single-ALU/single-memory datapath
// Ports:
//   Clk, Rst (sync, active-low)      clock and reset
//   Opcode, Funct                    instruction fields IR[31:26], IR[5:0]
//   MemReady, Zero                   memory handshake, ALU branch condition
//   PCWrite..Link, ALUSrcA/B, ALUOp,
//   PCSource, MemSize                per-cycle datapath controls
//   State                            current state (debug)
//   InstrDone, RetireCount           retire pulse and retired-instruction count
//   IllegalOp, MemErr                sticky error flags
module multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [5:0]       Opcode,
   input  logic [5:0]       Funct,
   input  logic             MemReady,
   input  logic             Zero,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             Link,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [5:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic [1:0]       MemSize,
   output logic [3:0]       State,
   output logic             InstrDone,
   output logic             IllegalOp,
   output logic             MemErr,
   output logic [CNT_W-1:0] RetireCount
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
      MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
      JAL = 4'd10, JR = 4'd11, EXECI = 4'd12
   } state_t;
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   state_t state, next, dec;
   logic [5:0] op;
   logic [TW-1:0] wait_cnt;
   logic mem_state, timeout, retire;
   logic [1:0] msz;
   // Zero only gates the PC write inside the datapath; the sequencer never looks at it.
   logic unused_zero;
   assign unused_zero = Zero;
   assign State = state;
   assign mem_state = state inside {FETCH, MEMRD, MEMWR};
   assign timeout = mem_state && !MemReady && wait_cnt == TW'(MEM_TIMEOUT - 1);
   assign retire = state inside {ALUWB, MEMWB, BRANCH, JUMP, JAL, JR} || (state == MEMWR && MemReady);
   // op[1:0]: 11 = word, 01 = half, 00 = byte for both loads and stores
   assign msz = op[1] ? 2'd0 : (op[0] ? 2'd1 : 2'd2);
   always_comb begin
      case (Opcode)
         6'h00:                             dec = (Funct == 6'h08) ? JR : EXEC;
         6'h08, 6'h0c, 6'h0d, 6'h0e:        dec = EXECI;
         6'h23, 6'h21, 6'h20,
         6'h2b, 6'h29, 6'h28:               dec = MEMADR;
         6'h01, 6'h04, 6'h05, 6'h06, 6'h07: dec = BRANCH;
         6'h02:                             dec = JUMP;
         6'h03:                             dec = JAL;
         default:                           dec = FETCH;
      endcase
   end
   always_comb begin
      case (state)
         FETCH:       next = MemReady ? DECODE : FETCH;
         DECODE:      next = dec;
         EXEC, EXECI: next = ALUWB;
         MEMADR:      next = op[3] ? MEMWR : MEMRD;
         MEMRD:       next = MemReady ? MEMWB : (timeout ? FETCH : MEMRD);
         MEMWR:       next = (MemReady || timeout) ? FETCH : MEMWR;
         default:     next = FETCH;
      endcase
   end
   always_comb begin
      {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
       RegWrite, Link, ALUSrcA, ALUSrcB, ALUOp, PCSource, MemSize} = '0;
      case (state)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'd1;
            ALUOp   = 6'h08;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         DECODE: begin
            ALUSrcB = 2'd3;
            ALUOp   = 6'h08;
         end
         EXEC: ALUSrcA = 1'b1;
         EXECI: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            ALUOp   = op;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            RegDst   = (op == 6'h00);
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            ALUOp   = 6'h08;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            MemSize = msz;
         end
         MEMWB: RegWrite = 1'b1;
         MEMWR: begin
            MemWrite = !timeout;
            IorD     = 1'b1;
            MemSize  = msz;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = op;
            PCWriteCond = 1'b1;
            PCSource    = 2'd1;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'd2;
         end
         JAL: begin
            PCWrite  = 1'b1;
            PCSource = 2'd2;
            RegWrite = 1'b1;
            Link     = 1'b1;
         end
         JR: begin
            PCWrite  = 1'b1;
            PCSource = 2'd3;
         end
         default: ;
      endcase
      // a reset cycle abandons the instruction, so nothing may strobe while Rst is low
      if (!Rst)
         {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
          RegWrite, Link, ALUSrcA, ALUSrcB, ALUOp, PCSource, MemSize} = '0;
   end
   assign InstrDone = Rst && retire;
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state       <= FETCH;
         op          <= '0;
         wait_cnt    <= '0;
         RetireCount <= '0;
         IllegalOp   <= 1'b0;
         MemErr      <= 1'b0;
      end else begin
         state <= next;
         if (state == DECODE) op <= Opcode;
         // leaving a memory state always passes through a ready or timeout cycle, clearing the count
         wait_cnt <= (mem_state && !MemReady && !timeout) ? wait_cnt + 1'b1 : '0;
         if (retire) RetireCount <= RetireCount + 1'b1;
         if (state == DECODE && dec == FETCH) IllegalOp <= 1'b1;
         if (timeout) MemErr <= 1'b1;
      end
   end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;
   localparam int CW = 4;
   localparam int TO = 16;
   logic Clk = 1'b0, Rst = 1'b0, MemReady = 1'b0, Zero = 1'b0;
   logic [5:0] Opcode = '0, Funct = '0;
   logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, Link, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource, MemSize;
   logic [5:0] ALUOp;
   logic [3:0] State;
   logic InstrDone, IllegalOp, MemErr;
   logic [CW-1:0] RetireCount;
   multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady), .Zero(Zero),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .Link(Link),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .MemSize(MemSize),
      .State(State), .InstrDone(InstrDone), .IllegalOp(IllegalOp), .MemErr(MemErr), .RetireCount(RetireCount)
   );
   always #5 Clk = ~Clk;
   typedef enum {K_ALU_R, K_ALU_I, K_JR, K_LOAD, K_STORE, K_BR, K_J, K_JAL, K_ILL} kind_t;
   typedef struct {
      int cyc; int rw; int mw; int done;
      int pcs; int link; int aluop; int msz; int rdst; int m2r;
      int rc; int ill; int merr;
   } rec_t;
   rec_t sbq[$];
   int checks = 0, errors = 0;
   bit mon_en = 0;
   int m_rc = 0;
   bit m_ill = 0, m_merr = 0;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask
   function automatic rec_t blank();
      rec_t r;
      r.cyc = 0; r.rw = 0; r.mw = 0; r.done = 0; r.pcs = 0; r.link = 0;
      r.aluop = 63; r.msz = 3; r.rdst = 0; r.m2r = 0; r.rc = 0; r.ill = 0; r.merr = 0;
      return r;
   endfunction
   function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'h00:                             return (f == 6'h08) ? K_JR : K_ALU_R;
         6'h08, 6'h0c, 6'h0d, 6'h0e:        return K_ALU_I;
         6'h23, 6'h21, 6'h20:               return K_LOAD;
         6'h2b, 6'h29, 6'h28:               return K_STORE;
         6'h01, 6'h04, 6'h05, 6'h06, 6'h07: return K_BR;
         6'h02:                             return K_J;
         6'h03:                             return K_JAL;
         default:                           return K_ILL;
      endcase
   endfunction
   // instruction-level expectation: cycles spent outside FETCH and what should be seen there
   function automatic rec_t predict(input kind_t k, input logic [5:0] o, input int d);
      rec_t e;
      bit to;
      e = blank();
      to = d >= TO;
      case (k)
         K_ALU_R: begin e.cyc = 3; e.rw = 1; e.aluop = 0; e.rdst = 1; e.m2r = 1; e.done = 1; end
         K_ALU_I: begin e.cyc = 3; e.rw = 1; e.aluop = o; e.m2r = 1; e.done = 1; end
         K_JR:    begin e.cyc = 2; e.pcs = 3; e.done = 1; end
         K_J:     begin e.cyc = 2; e.pcs = 2; e.done = 1; end
         K_JAL:   begin e.cyc = 2; e.pcs = 2; e.link = 1; e.rw = 1; e.done = 1; end
         K_BR:    begin e.cyc = 2; e.pcs = 1; e.aluop = o; e.done = 1; end
         K_LOAD, K_STORE: begin
            e.aluop = 8;
            e.msz = (o == 6'h23 || o == 6'h2b) ? 0 : (o == 6'h21 || o == 6'h29) ? 1 : 2;
            e.done = to ? 0 : 1;
            if (k == K_LOAD) begin
               e.cyc = to ? 2 + TO : 4 + d;
               e.rw = to ? 0 : 1;
            end else begin
               e.cyc = to ? 2 + TO : 3 + d;
               e.mw = to ? TO - 1 : d + 1;
            end
         end
         default: e.cyc = 1;
      endcase
      return e;
   endfunction
   // monitor: accumulate what the DUT shows outside FETCH, compare on return to FETCH
   rec_t a;
   logic [3:0] prev;
   always @(negedge Clk) begin
      if (!mon_en || !Rst) begin
         a = blank();
         prev = 4'd0;
      end else begin
         if (State != 4'd0) begin
            a.cyc++;
            a.rw += int'(RegWrite);
            a.mw += int'(MemWrite);
            a.done += int'(InstrDone);
            if (PCWrite || PCWriteCond) a.pcs = int'(PCSource);
            if (Link) a.link = 1;
            if (ALUSrcA) a.aluop = int'(ALUOp);
            if (IorD) a.msz = int'(MemSize);
            if (RegWrite && !Link) begin a.rdst = int'(RegDst); a.m2r = int'(MemtoReg); end
         end else begin
            chk("fetch_irwrite", int'(IRWrite), int'(MemReady));
            chk("fetch_pcwrite", int'(PCWrite), int'(MemReady));
            if (prev != 4'd0) begin
               if (sbq.size() == 0) begin
                  errors++;
                  $display("FAIL scoreboard: instruction ended with nothing expected (t=%0t)", $time);
               end else begin
                  rec_t e;
                  e = sbq.pop_front();
                  chk("cycles", a.cyc, e.cyc);
                  chk("regwrite_cycles", a.rw, e.rw);
                  chk("memwrite_cycles", a.mw, e.mw);
                  chk("instr_done", a.done, e.done);
                  chk("pcsource", a.pcs, e.pcs);
                  chk("link", a.link, e.link);
                  chk("aluop", a.aluop, e.aluop);
                  chk("memsize", a.msz, e.msz);
                  chk("regdst", a.rdst, e.rdst);
                  chk("memtoreg", a.m2r, e.m2r);
                  chk("retire_count", int'(RetireCount), e.rc);
                  chk("illegal_op", int'(IllegalOp), e.ill);
                  chk("mem_err", int'(MemErr), e.merr);
               end
               a = blank();
            end
         end
         prev = State;
      end
   end
   // driver: called at posedge+1 with the DUT in FETCH; returns at the first FETCH cycle after the instruction
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int d);
      rec_t e;
      kind_t k;
      int fc = 0, mc = 0;
      bit left = 0;
      k = classify(o, f);
      e = predict(k, o, d);
      m_rc = (m_rc + e.done) % (1 << CW);
      m_ill |= (k == K_ILL);
      m_merr |= ((k == K_LOAD || k == K_STORE) && d >= TO);
      e.rc = m_rc; e.ill = int'(m_ill); e.merr = int'(m_merr);
      sbq.push_back(e);
      for (int c = 0; c < 100; c++) begin
         if (c > 0) begin @(posedge Clk); #1; end
         case (State)
            4'd0: begin
               if (left) return;
               Opcode = o; Funct = f; MemReady = (fc >= fw); fc++;
            end
            4'd1: begin left = 1; Opcode = o; Funct = f; MemReady = 1'($urandom); end
            4'd3, 4'd5: begin Opcode = 6'($urandom); MemReady = (mc >= d); mc++; end
            default: begin Opcode = 6'($urandom); Funct = 6'($urandom); MemReady = 1'($urandom); end
         endcase
      end
      errors++;
      $display("FAIL instr_timeout: opcode %0h never returned to FETCH, state %0d", o, State);
   endtask
   initial begin
      logic [5:0] ops [20] = '{6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h21, 6'h20, 6'h2b,
                               6'h29, 6'h28, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03, 6'h3f};
      bit found;
      Rst = 1'b0; MemReady = 1'b1; Opcode = 6'h00; Funct = 6'h20;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_state", int'(State), 0);
      chk("rst_retire_count", int'(RetireCount), 0);
      chk("rst_illegal", int'(IllegalOp), 0);
      chk("rst_memerr", int'(MemErr), 0);
      chk("rst_pcwrite", int'(PCWrite), 0);
      chk("rst_irwrite", int'(IRWrite), 0);
      @(posedge Clk); #1;
      Rst = 1'b1; MemReady = 1'b0;
      repeat (15) @(posedge Clk);
      @(negedge Clk);
      chk("fetch_wait15_memerr", int'(MemErr), 0);
      @(negedge Clk);
      chk("fetch_timeout_memerr", int'(MemErr), 1);
      chk("fetch_timeout_state", int'(State), 0);
      @(posedge Clk); #1; Rst = 1'b0;
      @(posedge Clk); #1; Rst = 1'b1;
      chk("rst_clears_memerr", int'(MemErr), 0);
      mon_en = 1;
      run_instr(6'h00, 6'h20, 0, 0);
      run_instr(6'h23, 6'h00, 0, 3);
      run_instr(6'h20, 6'h00, 1, 3);
      run_instr(6'h29, 6'h00, 0, 0);
      run_instr(6'h04, 6'h00, 0, 0);
      run_instr(6'h03, 6'h00, 2, 0);
      run_instr(6'h00, 6'h08, 0, 0);
      run_instr(6'h3f, 6'h00, 0, 0);
      run_instr(6'h2b, 6'h00, 0, 15);
      run_instr(6'h21, 6'h00, 0, 16);
      for (int i = 0; i < 80; i++) begin
         logic [5:0] o, f;
         int d;
         o = ($urandom_range(0, 99) < 15) ? 6'($urandom) : ops[$urandom_range(0, 19)];
         f = (o == 6'h00 && $urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
         d = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 20) : $urandom_range(0, 5);
         run_instr(o, f, $urandom_range(0, 3), d);
      end
      MemReady = 1'b0;
      repeat (3) @(negedge Clk);
      chk("scoreboard_drained", sbq.size(), 0);
      mon_en = 0;
      Opcode = 6'h2b; Funct = 6'h00;
      found = 0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(posedge Clk); #1;
         if (State == 4'd5) found = 1;
         else MemReady = (State == 4'd0);
      end
      MemReady = 1'b0;
      chk("reach_memwr", int'(found), 1);
      @(negedge Clk);
      chk("memwr_memwrite", int'(MemWrite), 1);
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(negedge Clk);
      chk("rst_in_memwr_memwrite", int'(MemWrite), 0);
      chk("rst_in_memwr_done", int'(InstrDone), 0);
      @(posedge Clk); #1;
      chk("rst_in_memwr_state", int'(State), 0);
      chk("rst_in_memwr_count", int'(RetireCount), 0);
      Rst = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
